// File: rtl/triangle_decoder_if.sv
// Sample link carrying a triangle-wave stream
// and the tracking results returned by the decoder.
interface triangle_decoder_if #(
  parameter int N        = 8,
  parameter int PERIOD_W = 16
);
  logic                ena;
  logic [N-1:0]        in;
  logic                locked;
  logic                dir;
  logic                peak;
  logic                trough;
  logic                err;
  logic [7:0]          err_count;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;

  modport master (
    output ena, in,
    input  locked, dir, peak, trough, err,
    input  err_count, period, period_valid
  );

  modport slave (
    input  ena, in,
    output locked, dir, peak, trough, err,
    output err_count, period, period_valid
  );
endinterface

// File: rtl/triangle_decoder.sv
// Tracks a 0..MAX..0 triangle sample stream:
// lock, direction, turnaround events, period, step errors.
module triangle_decoder #(
  parameter int N        = 8,
  parameter int PERIOD_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  triangle_decoder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, PROBE, UP, DOWN
  } state_t;

  localparam logic [N:0] MAX_X = {1'b0, {N{1'b1}}};

  state_t              state, state_d;
  logic [N-1:0]        prev, prev_d;
  logic                peak_q, peak_d;
  logic                trough_q, trough_d;
  logic                err_q, err_d;
  logic [7:0]          errc_q, errc_d;
  logic [PERIOD_W-1:0] cnt, cnt_d;
  logic                have, have_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic                pv_q, pv_d;

  logic [N:0] s_x, inc_x, dec_x;
  logic       up_step, dn_step;
  logic       is_max, is_zero;
  logic       mis, tr;

  // Steps compared one bit wider so 0/MAX never wrap.
  assign s_x     = {1'b0, bus.in};
  assign inc_x   = {1'b0, prev} + (N+1)'(1);
  assign dec_x   = {1'b0, prev} - (N+1)'(1);
  assign up_step = (s_x == inc_x);
  assign dn_step = (s_x == dec_x);
  assign is_max  = (s_x == MAX_X);
  assign is_zero = (s_x == '0);

  // Next-state, event and period tracking logic.
  always_comb begin
    state_d  = state;
    prev_d   = prev;
    peak_d   = 1'b0;
    trough_d = 1'b0;
    err_d    = 1'b0;
    errc_d   = errc_q;
    cnt_d    = cnt;
    have_d   = have;
    per_d    = per_q;
    pv_d     = 1'b0;
    mis      = 1'b0;
    tr       = 1'b0;
    if (bus.ena) begin
      prev_d = bus.in;
      unique case (state)
        IDLE:  state_d = PROBE;
        PROBE: begin
          unique case (1'b1)
            up_step: begin
              state_d = is_max ? DOWN : UP;
              peak_d  = is_max;
            end
            dn_step: begin
              state_d = is_zero ? UP : DOWN;
              tr      = is_zero;
            end
            default: ;
          endcase
        end
        UP: begin
          if (up_step) begin
            if (is_max) begin
              state_d = DOWN;
              peak_d  = 1'b1;
            end
          end else begin
            mis = 1'b1;
          end
        end
        DOWN: begin
          if (dn_step) begin
            if (is_zero) begin
              state_d = UP;
              tr      = 1'b1;
            end
          end else begin
            mis = 1'b1;
          end
        end
      endcase
      if (state == UP || state == DOWN) begin
        cnt_d = (&cnt) ? cnt : cnt + PERIOD_W'(1);
      end
      if (tr) begin
        trough_d = 1'b1;
        if (have) begin
          per_d = (&cnt) ? cnt : cnt + PERIOD_W'(1);
          pv_d  = 1'b1;
        end
        cnt_d  = '0;
        have_d = 1'b1;
      end
      if (mis) begin
        err_d   = 1'b1;
        errc_d  = (&errc_q) ? errc_q : errc_q + 8'd1;
        state_d = PROBE;
        cnt_d   = '0;
        have_d  = 1'b0;
      end
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      prev     <= '0;
      peak_q   <= 1'b0;
      trough_q <= 1'b0;
      err_q    <= 1'b0;
      errc_q   <= '0;
      cnt      <= '0;
      have     <= 1'b0;
      per_q    <= '0;
      pv_q     <= 1'b0;
    end else begin
      state    <= state_d;
      prev     <= prev_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
      err_q    <= err_d;
      errc_q   <= errc_d;
      cnt      <= cnt_d;
      have     <= have_d;
      per_q    <= per_d;
      pv_q     <= pv_d;
    end
  end

  assign bus.locked       = (state == UP) || (state == DOWN);
  assign bus.dir          = (state == DOWN);
  assign bus.peak         = peak_q;
  assign bus.trough       = trough_q;
  assign bus.err          = err_q;
  assign bus.err_count    = errc_q;
  assign bus.period       = per_q;
  assign bus.period_valid = pv_q;
endmodule

// File: doc/triangle_decoder.md
# triangle_decoder

Consumes a stream of N-bit samples from a triangle-wave source (counts 0 → 2^N-1 → 0, one step per enabled sample) and tracks it. Reports lock, current direction, peak/trough events, measured period and step errors. Sits at the receiving end of any triangle-wave sample link, e.g. checking or decoding the cursor-sweep signals in the etch-a-sketch datapath.

## Interface
- N, 8, sample width (N >= 2)
- PERIOD_W, 16, width of period counter/output
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- ena  input  1  sample valid; sample accepted on rising clk when high
- in  input  N  sample value
- locked  output  1  high while tracking a valid slope
- dir  output  1  0 = counting up, 1 = counting down
- peak  output  1  one-cycle pulse: sample 2^N-1 accepted as turnaround
- trough  output  1  one-cycle pulse: sample 0 accepted as turnaround
- err  output  1  one-cycle pulse: step mismatch while locked
- err_count  output  8  accepted mismatches, saturates at 255
- period  output  PERIOD_W  samples between successive troughs
- period_valid  output  1  one-cycle pulse when period updates

## Operation
- State register: IDLE, PROBE, UP, DOWN. Internal prev[N-1:0] holds last accepted sample.
- All step comparisons done in N+1 bits: prev+1 never wraps to 0, prev-1 never wraps to max. MAX = 2^N-1.
- IDLE: on accepted s → prev=s, PROBE.
- PROBE (not locked): s==prev+1 → UP, or DOWN with peak pulse if s==MAX; s==prev-1 → DOWN, or UP with trough pulse if s==0; otherwise stay PROBE. No err. prev=s.
- UP: s==prev+1 → stay UP; if s==MAX → DOWN, peak pulse. Otherwise mismatch.
- DOWN: s==prev-1 → stay DOWN; if s==0 → UP, trough pulse. Otherwise mismatch.
- Mismatch (UP/DOWN only): err pulse, err_count+1 (saturating), state PROBE, prev=s, period tracking cleared. Repeated value counts as a mismatch.
- locked = state ∈ {UP, DOWN}; dir = (state == DOWN).
- Period tracking: flag have_trough and counter cnt[PERIOD_W-1:0].
  - Each accepted sample while locked: cnt+1, saturating at all-ones.
  - Trough pulse: if have_trough, period = cnt+1 (saturating) and period_valid pulse. Then cnt=0 and have_trough=1.
  - Leaving lock clears have_trough and cnt.
- ena low: no state, prev, counter or output change; all pulses low.

## Timing
- All outputs registered. Effects of a sample accepted at edge k are visible after edge k (one-cycle latency).
- Pulses (peak, trough, err, period_valid) last exactly one cycle, even with back-to-back ena.
- Reset (rst_n low at an edge): state IDLE, prev=0, locked=0, dir=0, peak=trough=err=period_valid=0, err_count=0, period=0, cnt=0, have_trough=0.
- Reset mid-stream takes priority over ena and discards all tracking.
- Lock takes 2 accepted samples from IDLE. Full-swing period = 2·(2^N-1) samples (510 for N=8).
- ena gaps of any length are transparent; only accepted samples count.

## Test plan
- Reset: hold rst_n=0 with ena=1 and random in → every output 0 and state IDLE. Release → first sample only moves to PROBE; locked stays 0.
- Clean sweep, N=4: feed 0,1,…,15,14,…,0,1,…,15,…,0 with ena=1 → locked after 2nd sample with dir=0; peak on sample 15; dir=1 after it; trough on each 0. First trough gives no period_valid; second gives period=30 and period_valid for one cycle. err_count stays 0.
- ena gaps: same sweep with ena low on random cycles → identical event sequence and period=30. Outputs hold during gaps.
- Glitch: while locked up at 5, feed 9 → err pulse, err_count=1, locked=0. Then 10,11 → relock with dir=0. Period is not reported until two troughs have been seen after relock.
- Boundary probe: from IDLE feed 15 then 0 (N=4) → stays PROBE, no err, no lock (wrap rejected). Feed 15,14 → DOWN with locked=1, and no peak pulse.
- Saturation: inject 300 mismatches while repeatedly relocking → err_count=255 and holds. Reset mid-sweep → everything returns to reset values on the next cycle.
